// File: rtl/mem_access_arbiter.sv
// RAM transaction sequencer and fetch/data arbiter for the microprogrammed ARM datapath.
// Optional define ROUND_ROBIN_EN replaces fixed data priority with alternating grants on contention.
module mem_access_arbiter #(
   parameter int unsigned ADDR_W      = 9,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_moc,
   input  logic              du_req,
   input  logic              du_rw,
   input  logic [1:0]        du_size,
   input  logic [ADDR_W-1:0] du_addr,
   input  logic [31:0]       du_wdata,
   output logic [31:0]       du_rdata,
   output logic              du_moc,
   output logic              du_err,
   output logic              mem_en,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state;
   logic [3:0]        cnt;
   logic              gnt_du;
   logic              lat_rw;
   logic [1:0]        lat_size;
   logic [1:0]        lat_off;
   logic              pick_du;
   logic              du_bad;
   logic [3:0]        du_be;
   logic [31:0]       du_wrep;
   logic [31:0]       du_rd;
   logic [ADDR_W-1:0] addr_mask;

   assign addr_mask = ~ADDR_W'(3);

`ifdef ROUND_ROBIN_EN
   logic last_du;
   // On contention the port that did not win last time is granted.
   assign pick_du = du_req & (~if_req | ~last_du);
`else
   assign pick_du = du_req;
`endif

   always_comb begin
      du_bad  = 1'b0;
      du_be   = 4'b1111;
      du_wrep = du_wdata;
      case (du_size)
         2'b00: begin
            du_be   = 4'b1000 >> du_addr[1:0];
            du_wrep = {4{du_wdata[7:0]}};
         end
         2'b01: begin
            du_bad  = du_addr[0];
            du_be   = du_addr[1] ? 4'b0011 : 4'b1100;
            du_wrep = {2{du_wdata[15:0]}};
         end
         2'b10:   du_bad = |du_addr[1:0];
         default: du_bad = 1'b1;
      endcase
   end

   // Big-endian lane extraction: offset 0 lives in the top byte.
   always_comb begin
      du_rd = mem_rdata;
      case (lat_size)
         2'b00:   du_rd = {24'h0, mem_rdata[{~lat_off, 3'b000} +: 8]};
         2'b01:   du_rd = {16'h0, lat_off[1] ? mem_rdata[15:0] : mem_rdata[31:16]};
         default: du_rd = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         gnt_du    <= 1'b0;
         lat_rw    <= 1'b0;
         lat_size  <= '0;
         lat_off   <= '0;
         if_rdata  <= '0;
         if_moc    <= 1'b0;
         du_rdata  <= '0;
         du_moc    <= 1'b0;
         du_err    <= 1'b0;
         mem_en    <= 1'b0;
         mem_rw    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
`ifdef ROUND_ROBIN_EN
         last_du   <= 1'b0;
`endif
      end else begin
         if_moc <= 1'b0;
         du_moc <= 1'b0;
         du_err <= 1'b0;
         case (state)
            IDLE: begin
               if (du_req || if_req) begin
                  gnt_du <= pick_du;
`ifdef ROUND_ROBIN_EN
                  last_du <= pick_du;
`endif
                  if (pick_du) begin
                     lat_rw   <= du_rw;
                     lat_size <= du_size;
                     lat_off  <= du_addr[1:0];
                     if (du_bad) begin
                        du_moc <= 1'b1;
                        du_err <= 1'b1;
                        state  <= RESP;
                     end else begin
                        mem_en    <= 1'b1;
                        mem_rw    <= du_rw;
                        mem_addr  <= du_addr & addr_mask;
                        mem_be    <= du_be;
                        mem_wdata <= du_wrep;
                        cnt       <= 4'(WAIT_CYCLES - 1);
                        state     <= ACCESS;
                     end
                  end else begin
                     lat_rw    <= 1'b1;
                     mem_en    <= 1'b1;
                     mem_rw    <= 1'b1;
                     mem_addr  <= if_addr & addr_mask;
                     mem_be    <= 4'b1111;
                     mem_wdata <= '0;
                     cnt       <= 4'(WAIT_CYCLES - 1);
                     state     <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (cnt == '0) begin
                  mem_en <= 1'b0;
                  if (gnt_du) begin
                     du_moc <= 1'b1;
                     if (lat_rw) du_rdata <= du_rd;
                  end else begin
                     if_moc   <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
                  state <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed table, corner sequences and random traffic vs a reference model.
module tb_mem_access_arbiter;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [8:0]  if_addr;
   logic [31:0] if_rdata;
   logic        if_moc;
   logic        du_req;
   logic        du_rw;
   logic [1:0]  du_size;
   logic [8:0]  du_addr;
   logic [31:0] du_wdata;
   logic [31:0] du_rdata;
   logic        du_moc;
   logic        du_err;
   logic        mem_en;
   logic        mem_rw;
   logic [8:0]  mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   mem_access_arbiter #(.ADDR_W(9), .WAIT_CYCLES(W)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_moc(if_moc),
      .du_req(du_req), .du_rw(du_rw), .du_size(du_size), .du_addr(du_addr),
      .du_wdata(du_wdata), .du_rdata(du_rdata), .du_moc(du_moc), .du_err(du_err),
      .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        access;
      logic [8:0]  maddr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      logic        du;
      logic        rw;
      logic [1:0]  size;
      logic [8:0]  addr;
      logic [31:0] wd;
      logic [31:0] rd;
      exp_t        e;
   } vec_t;

   typedef struct {
      int          lat;
      int          en_cnt;
      logic [8:0]  maddr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        rw;
      logic        err;
      logic        stable;
      logic        other_moc;
      logic        pulse_ok;
      logic [31:0] rdata;
   } obs_t;

   int errors = 0;
   int checks = 0;
   logic [31:0] m_if = '0;
   logic [31:0] m_du = '0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference: expected RAM command and port response from the lane rules, plain arithmetic.
   task automatic model(input logic du, input logic rw, input logic [1:0] size, input logic [8:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, output exp_t e);
      int k;
      k = int'(addr) % 4;
      e.err    = du && (size == 3 || (size == 1 && (k % 2) != 0) || (size == 2 && k != 0));
      e.access = !e.err;
      e.maddr  = addr - 9'(k);
      e.be     = 4'd15;
      e.wdata  = wd;
      if (!du) begin
         m_if    = rd;
         e.wdata = '0;
         e.rdata = m_if;
      end else begin
         if (size == 0) begin
            e.be    = 4'(1 << (3 - k));
            e.wdata = wd[7:0] * 32'h01010101;
         end else if (size == 1) begin
            e.be    = (k < 2) ? 4'd12 : 4'd3;
            e.wdata = wd[15:0] * 32'h00010001;
         end
         if (!e.err && rw) begin
            if (size == 0)      m_du = (rd >> (8 * (3 - k))) & 32'hFF;
            else if (size == 1) m_du = (rd >> (16 * (1 - k / 2))) & 32'hFFFF;
            else                m_du = rd;
         end
         e.rdata = m_du;
      end
   endtask

   task automatic run_txn(input logic du, input logic rw, input logic [1:0] size, input logic [8:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, output obs_t o);
      int start;
      bit done;
      o = '{lat: -1, en_cnt: 0, maddr: '0, be: '0, wdata: '0, rw: 1'b0, err: 1'b0,
            stable: 1'b1, other_moc: 1'b0, pulse_ok: 1'b0, rdata: '0};
      mem_rdata = rd;
      if (du) begin
         du_req = 1'b1; du_rw = rw; du_size = size; du_addr = addr; du_wdata = wd;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      start = cyc;
      done  = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(posedge clk); #1;
         if (mem_en) begin
            if (o.en_cnt == 0) begin
               o.maddr = mem_addr; o.be = mem_be; o.wdata = mem_wdata; o.rw = mem_rw;
            end else if ({mem_rw, mem_addr, mem_be, mem_wdata} != {o.rw, o.maddr, o.be, o.wdata}) begin
               o.stable = 1'b0;
            end
            o.en_cnt++;
         end
         if (du ? if_moc : du_moc) o.other_moc = 1'b1;
         if (du ? du_moc : if_moc) begin
            o.lat = cyc - start;
            o.err = du_err;
            done  = 1'b1;
         end
      end
      du_req = 1'b0;
      if_req = 1'b0;
      @(posedge clk); #1;
      o.pulse_ok = !(if_moc || du_moc || mem_en);
      o.rdata    = du ? du_rdata : if_rdata;
   endtask

   task automatic compare(input string tag, input logic du, input logic rw, input obs_t o, input exp_t e);
      chk({tag, " moc latency"}, 32'(o.lat), e.err ? 32'd1 : 32'(W + 1));
      chk({tag, " mem_en cycles"}, 32'(o.en_cnt), e.access ? 32'(W) : 32'd0);
      if (e.access) begin
         chk({tag, " mem_addr"}, 32'(o.maddr), 32'(e.maddr));
         chk({tag, " mem_be"}, 32'(o.be), 32'(e.be));
         chk({tag, " mem_rw"}, 32'(o.rw), du ? 32'(rw) : 32'd1);
         chk({tag, " access stable"}, 32'(o.stable), 32'd1);
         if (du && !rw) chk({tag, " mem_wdata"}, o.wdata, e.wdata);
      end
      chk({tag, " du_err"}, 32'(o.err), 32'(e.err));
      chk({tag, " rdata"}, o.rdata, e.rdata);
      chk({tag, " moc single pulse"}, 32'(o.pulse_ok), 32'd1);
      chk({tag, " other port moc"}, 32'(o.other_moc), 32'd0);
   endtask

   vec_t vecs[8];
   obs_t o;
   exp_t e;

   initial begin
      vecs[0] = '{1'b0, 1'b1, 2'b10, 9'h012, 32'h0,        32'hE0846004, '{1'b1, 9'h010, 4'hF, 32'h0,        1'b0, 32'hE0846004}};
      vecs[1] = '{1'b1, 1'b0, 2'b00, 9'h013, 32'h000000A5, 32'h0,        '{1'b1, 9'h010, 4'h1, 32'hA5A5A5A5, 1'b0, 32'h0}};
      vecs[2] = '{1'b1, 1'b1, 2'b00, 9'h011, 32'h0,        32'h11223344, '{1'b1, 9'h010, 4'h4, 32'h0,        1'b0, 32'h00000022}};
      vecs[3] = '{1'b1, 1'b1, 2'b01, 9'h012, 32'h0,        32'h11223344, '{1'b1, 9'h010, 4'h3, 32'h0,        1'b0, 32'h00003344}};
      vecs[4] = '{1'b1, 1'b1, 2'b10, 9'h002, 32'h0,        32'hDEADBEEF, '{1'b0, 9'h000, 4'h0, 32'h0,        1'b1, 32'h00003344}};
      vecs[5] = '{1'b1, 1'b1, 2'b11, 9'h010, 32'h0,        32'hDEADBEEF, '{1'b0, 9'h000, 4'h0, 32'h0,        1'b1, 32'h00003344}};
      vecs[6] = '{1'b1, 1'b0, 2'b01, 9'h010, 32'h0000BEEF, 32'h0,        '{1'b1, 9'h010, 4'hC, 32'hBEEFBEEF, 1'b0, 32'h00003344}};
      vecs[7] = '{1'b1, 1'b0, 2'b10, 9'h1FC, 32'h12345678, 32'h0,        '{1'b1, 9'h1FC, 4'hF, 32'h12345678, 1'b0, 32'h00003344}};

      reset = 1'b0; if_req = 1'b0; if_addr = '0; du_req = 1'b0; du_rw = 1'b0;
      du_size = '0; du_addr = '0; du_wdata = '0; mem_rdata = '0;
      #2;
      chk("outputs in reset", 32'(|{if_rdata, if_moc, du_rdata, du_moc, du_err, mem_en, mem_rw,
                                   mem_addr, mem_be, mem_wdata}), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         run_txn(vecs[i].du, vecs[i].rw, vecs[i].size, vecs[i].addr, vecs[i].wd, vecs[i].rd, o);
         compare($sformatf("vec%0d", i), vecs[i].du, vecs[i].rw, o, vecs[i].e);
      end

      // Asynchronous reset in the middle of a fetch access.
      mem_rdata = 32'hCAFEF00D; if_addr = 9'h020; if_req = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      #1 chk("outputs at async reset", 32'(|{if_rdata, if_moc, du_rdata, du_moc, du_err, mem_en, mem_rw,
                                              mem_addr, mem_be, mem_wdata}), 32'd0);
      if_req = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      begin
         bit busy;
         busy = 1'b0;
         repeat (5) begin
            @(posedge clk); #1;
            if (mem_en || if_moc || du_moc) busy = 1'b1;
         end
         chk("idle after reset release", 32'(busy), 32'd0);
      end
      m_if = '0;
      m_du = '0;

      // Contention: both held; data wins first, then the second pair goes by arbitration policy.
      begin
         int start, n;
         int lat[2];
         logic port[2];
         mem_rdata = 32'h5A5AA5A5;
         du_rw = 1'b1; du_size = 2'b10; du_addr = 9'h040; if_addr = 9'h080;
         du_req = 1'b1; if_req = 1'b1;
         start = cyc;
         n = 0;
         lat[0] = -1; lat[1] = -1; port[0] = 1'b0; port[1] = 1'b0;
         for (int k = 0; k < 60 && n < 2; k++) begin
            @(posedge clk); #1;
            if (du_moc || if_moc) begin
               lat[n]  = cyc - start;
               port[n] = du_moc;
               n++;
            end
         end
         du_req = 1'b0; if_req = 1'b0;
         @(posedge clk); #1;
         chk("contention first port is data", 32'(port[0]), 32'd1);
         chk("contention first latency", 32'(lat[0]), 32'(W + 1));
`ifdef ROUND_ROBIN_EN
         chk("contention second port is fetch", 32'(port[1]), 32'd0);
         m_if = 32'h5A5AA5A5;
`else
         chk("contention second port is data", 32'(port[1]), 32'd1);
`endif
         chk("contention second latency", 32'(lat[1]), 32'(2 * W + 3));
         m_du = 32'h5A5AA5A5;
      end

      for (int i = 0; i < 40; i++) begin
         logic        du, rw;
         logic [1:0]  size;
         logic [8:0]  addr;
         logic [31:0] wd, rd;
         du   = 1'($urandom_range(0, 1));
         rw   = 1'($urandom_range(0, 1));
         size = 2'($urandom_range(0, 3));
         addr = 9'($urandom);
         wd   = $urandom;
         rd   = $urandom;
         model(du, rw, size, addr, wd, rd, e);
         run_txn(du, rw, size, addr, wd, rd, o);
         compare($sformatf("rand%0d", i), du, rw, o, e);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
